// File: rtl/sources_dat_gen_pkg.sv
// Shared types, widths, taps and helper functions for the serial-link
// test-data source and its LFSR sub-module.
package sources_dat_pkg;

  localparam int DAT_W  = 15;
  localparam int DISP_W = 16;

  // Feedback taps of x^15 + x^14 + 1, as bit positions in the data word.
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  localparam logic [DAT_W-1:0] DEFAULT_MASTER_SEED = 15'h0001;
  localparam logic [DAT_W-1:0] DEFAULT_SLAVE_SEED  = 15'h7FFF;

  // The all-zero word is a dead end for this LFSR, so it is swapped for this value.
  localparam logic [DAT_W-1:0] ZERO_ESCAPE = 15'h0001;

  typedef logic [DAT_W-1:0]  dat_t;
  typedef logic [DISP_W-1:0] disp_t;

  // A zero seed would lock the generator, so it is replaced at reset.
  function automatic dat_t seed_fix(input dat_t seed);
    return (seed == '0) ? ZERO_ESCAPE : seed;
  endfunction

  // One Fibonacci step, with the zero lock-up guard folded in.
  function automatic dat_t lfsr_next(input dat_t dat);
    if (dat == '0) begin
      return ZERO_ESCAPE;
    end
    return {dat[DAT_W-2:0], dat[TAP_HI] ^ dat[TAP_LO]};
  endfunction

  function automatic disp_t to_disp(input dat_t dat);
    return {1'b0, dat};
  endfunction

endpackage

// File: rtl/sources_dat_gen_if.sv
// Payload bundle from the data source to the link transmitters and the
// hex display. There is no handshake; consumers sample whenever they want.
interface sources_dat_gen_if;
  import sources_dat_pkg::*;

  dat_t  MASTER_dat;
  disp_t MASTER_dat_disp;
  dat_t  SLAVE_dat;
  disp_t SLAVE_dat_disp;

  modport master (
    output MASTER_dat,
    output MASTER_dat_disp,
    output SLAVE_dat,
    output SLAVE_dat_disp
  );

  modport slave (
    input MASTER_dat,
    input MASTER_dat_disp,
    input SLAVE_dat,
    input SLAVE_dat_disp
  );

endinterface

// File: rtl/sources_dat_gen_lfsr15.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1) that steps only when enabled.
// A zero seed or a corrupted zero state recovers to 15'h0001.
module lfsr15
  import sources_dat_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  dat_t seed,
  output dat_t q
);

  // Load the sanitised seed on reset, otherwise advance one step per enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed_fix(seed);
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/sources_dat_gen.sv
// Test-data source: two independent LFSR payloads (master and slave) that
// advance together once every UPDATE_PERIOD clocks, plus zero-extended
// copies for the hex display.
module sources_dat_gen
  import sources_dat_pkg::*;
#(
  parameter int   UPDATE_PERIOD = 25_000_000,
  parameter dat_t MASTER_SEED   = DEFAULT_MASTER_SEED,
  parameter dat_t SLAVE_SEED    = DEFAULT_SLAVE_SEED
) (
  input logic              clk,
  input logic              rst,
  sources_dat_gen_if.master dat_if
);

  localparam int CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             upd;
  dat_t             master_q;
  dat_t             slave_q;
  disp_t            master_disp;
  disp_t            slave_disp;

  assign upd = (cnt == CNT_LAST);

  // Prescaler: free-running 0..UPDATE_PERIOD-1, restarted by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (upd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  lfsr15 u_master_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (upd),
    .seed (MASTER_SEED),
    .q    (master_q)
  );

  lfsr15 u_slave_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (upd),
    .seed (SLAVE_SEED),
    .q    (slave_q)
  );

  // Display copies load the same next value as the LFSRs so they never lag a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      master_disp <= to_disp(seed_fix(MASTER_SEED));
      slave_disp  <= to_disp(seed_fix(SLAVE_SEED));
    end else if (upd) begin
      master_disp <= to_disp(lfsr_next(master_q));
      slave_disp  <= to_disp(lfsr_next(slave_q));
    end
  end

  assign dat_if.MASTER_dat      = master_q;
  assign dat_if.MASTER_dat_disp = master_disp;
  assign dat_if.SLAVE_dat       = slave_q;
  assign dat_if.SLAVE_dat_disp  = slave_disp;

endmodule

// File: tb/tb_sources_dat_gen.sv
// Bench for sources_dat_gen. dut_a uses the lab defaults at period 4 and is
// tracked every cycle by a reference model feeding a scoreboard queue;
// dut_z has zero seeds; dut_p runs at period 2 to walk the full LFSR cycle.
module tb_sources_dat_gen;
  import sources_dat_pkg::*;

  localparam int PERIOD_A = 4;
  localparam int PERIOD_P = 2;
  localparam int LFSR_LEN = 32767;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    string      name;
    logic [14:0] mst;
    logic [14:0] slv;
  } exp_t;

  typedef struct {
    int          run_cycles;
    logic [14:0] mst;
    logic [14:0] slv;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];

  int          mdl_cnt = 0;
  logic [14:0] mdl_mst = 15'h0001;
  logic [14:0] mdl_slv = 15'h7FFF;

  // Free-running system clock.
  always #5 clk = ~clk;

  sources_dat_gen_if if_a ();
  sources_dat_gen_if if_z ();
  sources_dat_gen_if if_p ();

  sources_dat_gen #(
    .UPDATE_PERIOD (PERIOD_A),
    .MASTER_SEED   (15'h0001),
    .SLAVE_SEED    (15'h7FFF)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .dat_if (if_a)
  );

  sources_dat_gen #(
    .UPDATE_PERIOD (PERIOD_A),
    .MASTER_SEED   (15'h0000),
    .SLAVE_SEED    (15'h0000)
  ) dut_z (
    .clk    (clk),
    .rst    (rst),
    .dat_if (if_z)
  );

  sources_dat_gen #(
    .UPDATE_PERIOD (PERIOD_P),
    .MASTER_SEED   (15'h0001),
    .SLAVE_SEED    (15'h7FFF)
  ) dut_p (
    .clk    (clk),
    .rst    (rst),
    .dat_if (if_p)
  );

  // Reference LFSR step written arithmetically: shift left, feed back the parity of bits 14 and 13.
  function automatic logic [14:0] model_step(input logic [14:0] d);
    logic [15:0] shifted;
    logic        fb;
    if (d == 15'h0000) begin
      return 15'h0001;
    end
    shifted = {d, 1'b0};
    fb      = ^(d & 15'h6000);
    return shifted[14:0] | {14'd0, fb};
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%04h, wanted 0x%04h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, wanted an entry");
      return;
    end
    e = sb_q.pop_front();
    compare({e.name, " master"},      {1'b0, if_a.MASTER_dat}, {1'b0, e.mst});
    compare({e.name, " master_disp"}, if_a.MASTER_dat_disp,    {1'b0, e.mst});
    compare({e.name, " slave"},       {1'b0, if_a.SLAVE_dat},  {1'b0, e.slv});
    compare({e.name, " slave_disp"},  if_a.SLAVE_dat_disp,     {1'b0, e.slv});
  endtask

  // Drive one cycle of rst, advance the model, queue its prediction, then check after the edge.
  task automatic applyStimulus(input logic rst_val, input string name);
    exp_t e;
    rst = rst_val;
    if (rst_val) begin
      mdl_cnt = 0;
      mdl_mst = 15'h0001;
      mdl_slv = 15'h7FFF;
    end else if (mdl_cnt == PERIOD_A - 1) begin
      mdl_cnt = 0;
      mdl_mst = model_step(mdl_mst);
      mdl_slv = model_step(mdl_slv);
    end else begin
      mdl_cnt++;
    end
    e.name = name;
    e.mst  = mdl_mst;
    e.slv  = mdl_slv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [14:0] m_tmp;
    logic [14:0] s_tmp;
    int          zero_seen;
    int          early_one;

    // Known step values from seeds 0x0001 (master) and 0x7FFF (slave).
    for (int k = 1; k <= 13; k++) begin
      m_tmp = 15'h0001;
      m_tmp = m_tmp << k;
      s_tmp = 15'h7FFF;
      s_tmp = s_tmp << k;
      vecs[k-1] = '{PERIOD_A, m_tmp, s_tmp};
    end
    vecs[13] = '{PERIOD_A, 15'h4001, 15'h4000};
    vecs[14] = '{PERIOD_A, 15'h0003, 15'h0001};

    // Reset values.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, "reset");
    compare("reset master",      {1'b0, if_a.MASTER_dat}, 16'h0001);
    compare("reset master_disp", if_a.MASTER_dat_disp,    16'h0001);
    compare("reset slave",       {1'b0, if_a.SLAVE_dat},  16'h7FFF);
    compare("reset slave_disp",  if_a.SLAVE_dat_disp,     16'h7FFF);
    compare("zero seed master",  {1'b0, if_z.MASTER_dat}, 16'h0001);
    compare("zero seed slave",   {1'b0, if_z.SLAVE_dat},  16'h0001);

    // Step sequence from the table; the scoreboard also checks stability between steps.
    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < vecs[v].run_cycles; c++) begin
        applyStimulus(1'b0, $sformatf("step%0d", v + 1));
      end
      compare($sformatf("table step%0d master", v + 1), {1'b0, if_a.MASTER_dat}, {1'b0, vecs[v].mst});
      compare($sformatf("table step%0d slave", v + 1),  {1'b0, if_a.SLAVE_dat},  {1'b0, vecs[v].slv});
      if (v == 0) begin
        compare("zero seed master step1", {1'b0, if_z.MASTER_dat}, 16'h0002);
        compare("zero seed slave step1",  {1'b0, if_z.SLAVE_dat},  16'h0002);
      end
    end

    // Display consistency over a long stretch.
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, "disp");

    // Align to just after a step, then reset two cycles later.
    for (int i = 0; i < 2 * PERIOD_A && mdl_cnt != 0; i++) applyStimulus(1'b0, "align");
    applyStimulus(1'b0, "post_step");
    applyStimulus(1'b0, "post_step");
    applyStimulus(1'b1, "mid_reset");
    compare("mid reset master", {1'b0, if_a.MASTER_dat}, 16'h0001);
    compare("mid reset slave",  {1'b0, if_a.SLAVE_dat},  16'h7FFF);
    for (int i = 0; i < PERIOD_A - 1; i++) applyStimulus(1'b0, "restart");
    compare("restart hold master", {1'b0, if_a.MASTER_dat}, 16'h0001);
    applyStimulus(1'b0, "restart");
    compare("restart step master", {1'b0, if_a.MASTER_dat}, 16'h0002);
    compare("restart step slave",  {1'b0, if_a.SLAVE_dat},  16'h7FFE);

    // Reset in the same cycle as the update strobe.
    for (int i = 0; i < PERIOD_A - 1; i++) applyStimulus(1'b0, "to_upd");
    applyStimulus(1'b1, "collide");
    compare("collide master", {1'b0, if_a.MASTER_dat}, 16'h0001);
    compare("collide slave",  {1'b0, if_a.SLAVE_dat},  16'h7FFF);

    // Full LFSR cycle on the period-2 instance.
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    zero_seen = 0;
    early_one = 0;
    for (int i = 1; i <= LFSR_LEN * PERIOD_P; i++) begin
      @(posedge clk);
      #1;
      if (if_p.MASTER_dat == 15'h0000) zero_seen++;
      if (i >= 2 && i <= LFSR_LEN * PERIOD_P - 1 && if_p.MASTER_dat == 15'h0001) early_one++;
      if (i == (LFSR_LEN - 1) * PERIOD_P) begin
        compare("period predecessor", {1'b0, if_p.MASTER_dat}, 16'h4000);
      end
    end
    compare("period return master", {1'b0, if_p.MASTER_dat}, 16'h0001);
    compare("period return disp",   if_p.MASTER_dat_disp,    16'h0001);
    compare("period zero count",    16'(zero_seen),          16'd0);
    compare("period early return",  16'(early_one),          16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sources_dat_gen.md
# sources_dat_gen

Test-data source block for the master/slave serial link lab. It produces two independent 15-bit pseudo-random data words: one for the master transmitter and one for the slave transmitter. Each word also comes as a 16-bit zero-extended copy for the 4-digit hex display driver. Both words advance together once per programmable update period, so the link under test always has fresh, non-zero payloads.

## Interface
Parameters:
- `UPDATE_PERIOD`, default 25_000_000: clock cycles between data updates; legal range ≥ 2.
- `MASTER_SEED`, default 15'h0001: reset value of the master word; a value of 0 is replaced by 15'h0001.
- `SLAVE_SEED`, default 15'h7FFF: reset value of the slave word; a value of 0 is replaced by 15'h0001.

Ports:
- `clk`  in  1: the single system clock; all state updates on the rising edge.
- `rst`  in  1: reset, **synchronous, active-high**.
- `MASTER_dat`  out  15: current master payload.
- `MASTER_dat_disp`  out  16: `{1'b0, MASTER_dat}` for the display.
- `SLAVE_dat`  out  15: current slave payload.
- `SLAVE_dat_disp`  out  16: `{1'b0, SLAVE_dat}` for the display.

All outputs are registered.

## Operation
- **Reset values:** while `rst`=1 at a clock edge:
  - prescaler ← 0.
  - `MASTER_dat` ← MASTER_SEED (or 1 if the seed is 0).
  - `SLAVE_dat` ← SLAVE_SEED (or 1 if the seed is 0).
  - Each `_disp` output ← `{0, corresponding seed}`.
- **Prescaler:** counts 0 … UPDATE_PERIOD−1, then wraps to 0. The counter width is `$clog2(UPDATE_PERIOD)`. A one-cycle internal strobe `upd` is high when the count equals UPDATE_PERIOD−1.
- **LFSR step on `upd`:** both words step once.
  - Fibonacci LFSR, polynomial x^15+x^14+1 (maximal length, period 32767).
  - next = `{dat[13:0], dat[14]^dat[13]}`.
- **No update without `upd`:** the words hold their value.
- **Zero lock-up guard:** if a word is ever 0 (seed or corruption), the next step loads 15'h0001 instead of the LFSR result.
- **Display outputs:** registered in the same cycle as their data word, so a `_disp` output never differs from `{0, _dat}` at any edge.
- **Master and slave independence:** the two words share the strobe but never share state. With different seeds they follow different points of the same sequence.

## Timing
- **After reset release:** the first `upd` occurs in the UPDATE_PERIOD-th cycle. The new words are visible on the next edge, i.e. UPDATE_PERIOD cycles after the first non-reset edge.
- **Steady state:** exactly one step every UPDATE_PERIOD cycles, with no jitter.
- **Latency:** `upd` to new output is 1 cycle.
- **Reset mid-period:** reset has priority over `upd` when both occur at the same edge. The prescaler and both words reload immediately and the period restarts from 0.
- There is no handshake and no backpressure; consumers sample the outputs whenever they need them.

## Structure
- **Shared package `sources_dat_pkg`:**
  - `DAT_W` = 15 and `DISP_W` = 16.
  - LFSR tap constants (14, 13).
  - Default seed constants.
- **Sub-module `lfsr15`:** ports clk, rst, en, seed, q. It implements the step rule and the zero guard, and is instantiated twice (master and slave).
- **Top level:** holds the prescaler and the display registers.

## Test plan
All scenarios use UPDATE_PERIOD=4 unless stated otherwise.
1. **Reset values:** assert `rst` for 3 cycles → `MASTER_dat`=0x0001, `MASTER_dat_disp`=0x0001, `SLAVE_dat`=0x7FFF, `SLAVE_dat_disp`=0x7FFF.
2. **Step sequence:** release reset and run 4, 8, 12 … cycles → master goes 0x0002, 0x0004, …, 0x2000 (step 13), 0x4001 (step 14), 0x0003 (step 15). Slave goes 0x7FFE after step 1. Outputs are stable between steps.
3. **Display consistency:** check every cycle for 200 cycles → `_disp[15]`=0 and `_disp[14:0]`==`_dat` at every cycle.
4. **Reset mid-period and collision:** assert `rst` 2 cycles after a step → both words return to their seeds and the next step comes 4 cycles after release. Also assert `rst` in the `upd` cycle → the seed is loaded, not the stepped value.
5. **Zero seed:** MASTER_SEED=0 → after reset `MASTER_dat`=0x0001, and the first step gives 0x0002.
6. **Period:** run 32767×4 cycles from reset → master returns to 0x0001 and is never 0 along the way.
